// File: rtl/traffic_pkg.sv
// Shared signal-head encoding, phase type and helpers for the intersection
// phase scheduler.
package traffic_pkg;

  // Signal head encoding, shared with the existing traffic signal block.
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  // Widest intersection the all-RED helper can describe.
  localparam int MAX_APPR = 16;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_t;

  // All-RED head pattern for an n-approach intersection, in the low 2*n bits.
  function automatic logic [2*MAX_APPR-1:0] all_red(input int n);
    logic [2*MAX_APPR-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_APPR; i++) begin
      if (i < n) p[2*i +: 2] = RED;
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: finds the first pending approach after
// the current one, wrapping modulo N_APPR, and flags whether any exists.
module rr_pick #(
  parameter int N_APPR = 4,
  localparam int IDX_W = $clog2(N_APPR)
) (
  input  logic [N_APPR-1:0] pending,
  input  logic [IDX_W-1:0]  cur_idx,
  output logic [IDX_W-1:0]  next_idx,
  output logic              any_other
);

  // Search from farthest to nearest so the nearest pending approach wins.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    next_idx  = cur_idx;
    any_other = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = N_APPR - 1; k >= 1; k--) begin
      sum = {1'b0, cur_idx} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_APPR)) sum = sum - (IDX_W+1)'(N_APPR);
      cand = sum[IDX_W-1:0];
      if (pending[cand]) begin
        next_idx  = cand;
        any_other = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Shared-green phase scheduler: approach 0 rests green, side-road requests are
// latched and served round-robin through GREEN -> YELLOW -> ALLRED.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int N_APPR    = 4,
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 8,
  localparam int IDX_W    = $clog2(N_APPR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_APPR-1:0]     req,
  output logic [2*N_APPR-1:0]   sig_out,
  output logic [IDX_W-1:0]      active_idx,
  output logic [1:0]            phase,
  output logic                  phase_change
);

  localparam logic [2*MAX_APPR-1:0] ALL_RED_W = all_red(N_APPR);
  localparam logic [2*N_APPR-1:0]   ALL_RED   = ALL_RED_W[2*N_APPR-1:0];

  phase_t              ph;
  logic [CNT_W-1:0]    timer;
  logic [N_APPR-1:0]   pending;
  logic [N_APPR-1:0]   eff_pending;
  logic [IDX_W-1:0]    next_idx;
  logic [IDX_W-1:0]    pick_idx;
  logic                any_other;
  logic                green_exit;
  logic                yellow_done;
  logic                allred_done;

  // Head pattern with one approach showing the given colour, all others RED.
  function automatic logic [2*N_APPR-1:0] head_on(input logic [1:0] head,
                                                  input logic [IDX_W-1:0] idx);
    logic [2*N_APPR-1:0] s;
    s = ALL_RED;
    s[int'(idx)*2 +: 2] = head;
    return s;
  endfunction

  assign phase = ph;

  // Home approach is implicitly waiting whenever a side road owns the phase.
  always_comb begin
    eff_pending = pending;
    if (active_idx != '0) eff_pending[0] = 1'b1;
  end

  rr_pick #(.N_APPR(N_APPR)) u_rr_pick (
    .pending   (eff_pending),
    .cur_idx   (active_idx),
    .next_idx  (pick_idx),
    .any_other (any_other)
  );

  // A held sensor extends green up to MAX_GREEN; a quiet one releases at MIN_GREEN.
  assign green_exit  = (ph == PH_GREEN) && (timer >= CNT_W'(MIN_GREEN - 1)) && any_other &&
                       (!req[active_idx] || (timer == CNT_W'(MAX_GREEN - 1)));
  assign yellow_done = (ph == PH_YELLOW) && (timer == CNT_W'(YELLOW_T - 1));
  assign allred_done = (ph == PH_ALLRED) && (timer == CNT_W'(ALLRED_T - 1));

  // Latch requests; the grant edge clears the winner's bit even if it is re-requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < N_APPR; i++) begin
        if (allred_done && (next_idx == IDX_W'(i)))
          pending[i] <= 1'b0;
        else if (req[i] && !((ph == PH_GREEN) && (active_idx == IDX_W'(i))))
          pending[i] <= 1'b1;
      end
    end
  end

  // Phase sequencer with registered heads, owner index and grant pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph           <= PH_GREEN;
      timer        <= '0;
      active_idx   <= '0;
      next_idx     <= '0;
      phase_change <= 1'b0;
      sig_out      <= head_on(GREEN, '0);
    end else begin
      phase_change <= 1'b0;
      case (ph)
        PH_GREEN: begin
          if (green_exit) begin
            ph       <= PH_YELLOW;
            timer    <= '0;
            next_idx <= pick_idx;
            sig_out  <= head_on(YELLOW, active_idx);
          end else if (timer != CNT_W'(MAX_GREEN - 1)) begin
            timer <= timer + 1'b1;
          end
        end
        PH_YELLOW: begin
          if (yellow_done) begin
            ph      <= PH_ALLRED;
            timer   <= '0;
            sig_out <= ALL_RED;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PH_ALLRED: begin
          if (allred_done) begin
            ph           <= PH_GREEN;
            timer        <= '0;
            active_idx   <= next_idx;
            phase_change <= 1'b1;
            sig_out      <= head_on(GREEN, next_idx);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          ph      <= PH_GREEN;
          timer   <= '0;
          sig_out <= head_on(GREEN, active_idx);
        end
      endcase
    end
  end

endmodule
